// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Alignment rejection is compiled in only when DM_ARB_ALIGN_CHK_EN is defined.
package dm_arb_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // A word access must start on a 4-byte boundary and fit entirely inside memory.
   function automatic logic word_misaligned(input logic byteop, input logic [1:0] lsb,
                                            input logic past_end);
      return !byteop && ((lsb != 2'b00) || past_end);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the port that was not granted last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       last_gnt,
   output logic       valid,
   output logic       winner
);

   logic [1:0] eff;

   assign eff    = req & ~mask;
   assign valid  = |eff;
   assign winner = (&eff) ? ~last_gnt : eff[1];

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer for the single-port 1 KB data memory.
// Optional alignment rejection: define DM_ARB_ALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating raw requests
// ACCESS | memory pins driven from request registers, result captured at exit
// DONE   | ack of winner high, re-arbitrating with the winner masked
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          byteop0,
   input  logic          byteop1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   output logic          mem_byteop,
   input  logic [DW-1:0] mem_dout
);

   state_t        state_q;
   logic          last_gnt_q;
   logic          win_q;
   logic          we_q;
   logic          byteop_q;
   logic          rej_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          ack0_q;
   logic          ack1_q;
   logic          err_q;
   logic [DW-1:0] rdata_q;

   logic [1:0]    mask;
   logic          pick_valid;
   logic          pick_win;
   logic          latch;
   logic          sel_we;
   logic          sel_byteop;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_rej;

   // In DONE the current winner still holds req for one more cycle.
   assign mask = (state_q == ST_DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;

   rr_pick2 u_pick (
      .req      ({req1, req0}),
      .mask     (mask),
      .last_gnt (last_gnt_q),
      .valid    (pick_valid),
      .winner   (pick_win)
   );

   assign latch      = pick_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign sel_we     = pick_win ? we1     : we0;
   assign sel_byteop = pick_win ? byteop1 : byteop0;
   assign sel_addr   = pick_win ? addr1   : addr0;
   assign sel_wdata  = pick_win ? wdata1  : wdata0;

`ifdef DM_ARB_ALIGN_CHK_EN
   localparam logic [AW-1:0] LAST_WORD = ~AW'(3);
   assign sel_rej = word_misaligned(sel_byteop, sel_addr[1:0], sel_addr > LAST_WORD);
`else
   assign sel_rej = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= 1'b1;
         win_q      <= PORT_CPU;
         we_q       <= 1'b0;
         byteop_q   <= 1'b0;
         rej_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) state_q <= ST_ACCESS;
            end
            ST_ACCESS: begin
               rdata_q    <= (we_q || rej_q) ? '0 : mem_dout;
               err_q      <= rej_q;
               last_gnt_q <= win_q;
               ack0_q     <= (win_q == PORT_CPU);
               ack1_q     <= (win_q == PORT_AUX);
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               state_q <= pick_valid ? ST_ACCESS : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (latch) begin
            win_q    <= pick_win;
            we_q     <= sel_we;
            byteop_q <= sel_byteop;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            rej_q    <= sel_rej;
         end
      end
   end

   // Write strobe follows the state register so a reset mid-access kills it at once.
   assign mem_we     = (state_q == ST_ACCESS) && we_q && !rej_q;
   assign mem_addr   = addr_q;
   assign mem_din    = wdata_q;
   assign mem_byteop = byteop_q;
   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural memory and reference model.
// Build with DM_ARB_ALIGN_CHK_EN defined to exercise alignment rejection.
module tb_dm_arbiter;

   typedef struct packed {
      logic        we;
      logic        byteop;
      logic [9:0]  addr;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, byteop0, byteop1;
   logic [9:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, err, busy, mem_we, mem_byteop;
   logic [31:0] rdata, mem_din, mem_dout;
   logic [9:0]  mem_addr;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   last_gnt_m;
   bit   we_seen;
   exp_t sbq[$];

   logic [7:0] mem [1024];
   byte unsigned ref_mem [1024];

   dm_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .byteop0(byteop0), .byteop1(byteop1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_byteop(mem_byteop), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte-addressable little-endian memory, byte loads sign-extended.
   always_comb begin
      mem_dout = 32'h0;
      if (mem_byteop) mem_dout = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      else mem_dout = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                       mem[mem_addr + 10'd1], mem[mem_addr]};
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (mem_we) begin
            if (mem_byteop) mem[mem_addr] <= mem_din[7:0];
            else begin
               mem[mem_addr]         <= mem_din[7:0];
               mem[mem_addr + 10'd1] <= mem_din[15:8];
               mem[mem_addr + 10'd2] <= mem_din[23:16];
               mem[mem_addr + 10'd3] <= mem_din[31:24];
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: applies one access to the expected memory image.
   task automatic apply_op(input op_t o, output logic [31:0] rd, output bit er);
      int a;
      int v;
      bit rej;
      a   = int'(o.addr);
      rej = 1'b0;
`ifdef DM_ARB_ALIGN_CHK_EN
      rej = !o.byteop && ((a % 4) != 0 || a > 1020);
`endif
      rd = 32'h0;
      er = rej;
      if (rej) return;
      if (o.we) begin
         if (o.byteop) ref_mem[a] = o.wdata[7:0];
         else for (int i = 0; i < 4; i++) ref_mem[(a + i) % 1024] = o.wdata[8*i +: 8];
      end else if (o.byteop) begin
         v = int'(ref_mem[a]);
         if (v >= 128) v = v - 256;
         rd = 32'(v);
      end else begin
         for (int i = 0; i < 4; i++) rd = rd + (32'(ref_mem[(a + i) % 1024]) << (8 * i));
      end
   endtask

   function automatic op_t mk_op(input bit w, input bit b, input int a, input logic [31:0] d);
      op_t o;
      o.we = w; o.byteop = b; o.addr = 10'(a); o.wdata = d;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.we     = 1'($urandom_range(0, 1));
      o.byteop = 1'($urandom_range(0, 1));
      o.addr   = 10'(32'h100 + $urandom_range(0, 31));
      if (!o.byteop && $urandom_range(0, 3) != 0) o.addr[1:0] = 2'b00;
      o.wdata  = $urandom;
      return o;
   endfunction

   always @(negedge clk) if (mem_we) we_seen = 1'b1;

   always @(negedge clk) begin
      if (!rst && (ack0 || ack1)) begin
         exp_t e;
         check("ack_onehot", 32'(ack0 && ack1), 32'd0);
         if (sbq.size() == 0) begin
            check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("ack_port", 32'(ack1), 32'(e.port));
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
            check("rdata", rdata, e.rdata);
            check("err", 32'(err), 32'(e.err));
         end
      end
   end

   // Raise the enabled requests together from IDLE and hold each until its ack.
   task automatic run_round(input bit e0, input bit e1, input op_t o0, input op_t o1);
      int          k;
      bit          first, d0, d1, s0, s1, p;
      exp_t        e;
      logic [31:0] rd;
      bit          er;
      @(negedge clk);
      k = cyc + 1;
      first = (e0 && e1) ? !last_gnt_m : e1;
      for (int n = 0; n < 2; n++) begin
         p = (n == 0) ? first : !first;
         if ((!p && e0) || (p && e1)) begin
            apply_op(p ? o1 : o0, rd, er);
            e.port = p; e.rdata = rd; e.err = er; e.cyc = k + 1 + 2 * n;
            sbq.push_back(e);
            last_gnt_m = p;
         end
      end
      req0 = e0; we0 = o0.we; byteop0 = o0.byteop; addr0 = o0.addr; wdata0 = o0.wdata;
      req1 = e1; we1 = o1.we; byteop1 = o1.byteop; addr1 = o1.addr; wdata1 = o1.wdata;
      d0 = !e0;
      d1 = !e1;
      for (int t = 0; t < 12 && !(d0 && d1); t++) begin
         @(negedge clk);
         s0 = ack0;
         s1 = ack1;
         @(posedge clk);
         #1;
         if (s0) begin req0 = 1'b0; d0 = 1'b1; end
         if (s1) begin req1 = 1'b0; d1 = 1'b1; end
      end
      check("round_done", {30'd0, d1, d0}, 32'd3);
      req0 = 1'b0;
      req1 = 1'b0;
      addr0 = 10'($urandom); wdata0 = $urandom; we0 = 1'($urandom_range(0, 1));
      addr1 = 10'($urandom); wdata1 = $urandom; we1 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   initial begin
      op_t nop;
      bit  a, b;
      nop = mk_op(0, 0, 0, 0);
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; byteop0 = 0; byteop1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      last_gnt_m = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_byteop", 32'(mem_byteop), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_round(1, 0, mk_op(1, 0, 'h010, 32'hDEADBEEF), nop);
      run_round(1, 0, mk_op(0, 0, 'h010, 32'h0), nop);
      run_round(0, 1, nop, mk_op(1, 1, 'h3A5, 32'h000000F0));
      run_round(0, 1, nop, mk_op(0, 1, 'h3A5, 32'h0));
      run_round(0, 1, nop, mk_op(0, 0, 'h3A4, 32'h0));

      // Reset during ACCESS of a store: nothing committed, no ack.
      @(negedge clk);
      req0 = 1; we0 = 1; byteop0 = 0; addr0 = 10'h020; wdata0 = 32'h55AA55AA;
      @(posedge clk);
      #1;
      check("rstmid_busy", 32'(busy), 32'd1);
      check("rstmid_we_pre", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rstmid_we_drop", 32'(mem_we), 32'd0);
      check("rstmid_busy_drop", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("rstmid_no_ack", {30'd0, ack1, ack0}, 32'd0);
      req0 = 0;
      last_gnt_m = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      run_round(1, 1, rand_op(), rand_op());
      run_round(1, 1, rand_op(), rand_op());
      run_round(1, 0, mk_op(0, 0, 'h020, 32'h0), nop);
      run_round(1, 1, rand_op(), rand_op());

      we_seen = 1'b0;
      run_round(1, 0, mk_op(1, 0, 'h003, 32'h11223344), nop);
      run_round(0, 1, nop, mk_op(1, 0, 'h3FE, 32'hA5A5A5A5));
`ifdef DM_ARB_ALIGN_CHK_EN
      check("align_we_seen", 32'(we_seen), 32'd0);
`else
      check("align_we_seen", 32'(we_seen), 32'd1);
`endif
      run_round(1, 0, mk_op(0, 0, 'h000, 32'h0), nop);
      run_round(0, 1, nop, mk_op(0, 0, 'h3FC, 32'h0));

      for (int r = 0; r < 40; r++) begin
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         if (!a && !b) a = 1'b1;
         run_round(a, b, rand_op(), rand_op());
      end

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the single-port byte-addressable 1 KB data memory. Port 0 is the CPU load/store unit; port 1 is a secondary master (debug/DMA loader). The block grants one request at a time with round-robin fairness, drives the memory's address, data, write-enable and byte-op pins from registered request state, captures read data, and acknowledges the winner.

## Interface
- AW, 10, byte-address width (memory depth 2^AW bytes)
- DW, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request, held high until ack seen
- we0 / we1  in  1  1 = store, 0 = load
- byteop0 / byteop1  in  1  1 = byte access, 0 = word access
- addr0 / addr1  in  AW  byte address
- wdata0 / wdata1  in  DW  store data (byte stores use [7:0])
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DW  load data, valid while any ack is high
- err  out  1  access rejected, valid while any ack is high
- busy  out  1  state != IDLE
- mem_addr  out  AW  to memory addr
- mem_din  out  DW  to memory din
- mem_we  out  1  to memory we
- mem_byteop  out  1  to memory byteOp
- mem_dout  in  DW  from memory dout (combinational read)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, pick winner, latch we/byteop/addr/wdata of winner into request registers, record winner index, go ACCESS; else stay.
- Winner pick: one requester -> it; both -> port not granted last (last_gnt register, reset value 1 so port 0 wins first tie).
- ACCESS: mem_* driven from request registers; mem_we = we_q & ~reject. At the closing edge: memory commits store; rdata <= mem_dout (loads) or 0 (stores, rejects); err <= reject; last_gnt <= winner; go DONE.
- DONE: ack of winner high for exactly this cycle. Re-arbitrate with winner's req masked (requester still holds it this cycle); pending other port -> latch, go ACCESS; else IDLE.
- Requester must keep request fields stable from req rise until ack, and drop req the cycle after ack.
- mem_addr/mem_din/mem_byteop hold last latched values outside ACCESS; mem_we is 0 outside ACCESS.
- reject = 0 unless the Configuration feature is enabled.

## Timing
- Reset values: state IDLE, last_gnt 1, ack0/ack1 0, rdata 0, err 0, busy 0, mem_addr 0, mem_din 0, mem_we 0, mem_byteop 0.
- Latency: req sampled high at edge k -> ACCESS during cycle k..k+1 -> ack high during cycle k+1..k+2 (2 cycles req-to-ack).
- Throughput: back-to-back between ports, one access per 2 cycles; same port re-requesting waits through IDLE (3-cycle spacing).
- Fairness: with both req continuously high, grants alternate 0,1,0,1; no port waits more than one other access.
- Simultaneous req0/req1 in IDLE: resolved by last_gnt as above.
- rst asserted mid-ACCESS: mem_we drops asynchronously, store not committed, no ack issued; requester must re-request after rst release.
- rst asserted during DONE: ack drops immediately.

## Configuration
- DM_ARB_ALIGN_CHK_EN defined: reject = 1 when a word access has addr[1:0] != 0 or addr > 2^AW - 4. Rejected access: mem_we held 0, rdata = 0, err = 1 on ack; timing unchanged.
- Undefined: no checking; all accesses forwarded as issued; err constant 0.

## Structure
- Shared package dm_arb_pkg: state encodings (IDLE, ACCESS, DONE), port index constants (PORT_CPU = 0, PORT_AUX = 1), default AW/DW.
- Sub-module rr_pick2: combinational 2-way round-robin picker (inputs req vector, mask, last_gnt; outputs valid, winner index). Remainder (FSM, request registers, response registers) in dm_arbiter.

## Test plan
- Single store then load, port 0: store addr 0x010 word 0xDEADBEEF, then load 0x010 -> ack0 2 cycles after each req, rdata 0xDEADBEEF, err 0, ack1 never high.
- Byte path, port 1: byte store 0x3A5 data 0x000000F0, load byte 0x3A5 -> rdata 0xFFFFFFF0; word load 0x3A4 -> rdata 0x0000F000.
- Contention: req0 and req1 raised same cycle after reset, both held -> ack0 first, ack1 2 cycles later; repeated requests alternate 0,1,0,1.
- Reset mid-ACCESS: store 0x55AA55AA to 0x020, rst pulsed during ACCESS -> no ack, later load 0x020 returns 0.
- With DM_ARB_ALIGN_CHK_EN: word store to 0x003 and to 0x3FE -> ack with err 1, mem_we never high, loads of 0x000 and 0x3FC unchanged; without macro the same stores are forwarded and err stays 0.
